regfile: RTL and testbench
==========================

Name: regfile

Overview:
- 32 x 32-bit general-purpose register file for the CPU decode stage.
- Two read ports drive the ALU operand inputs a/b, directly or via the operand mux.
- One write port takes the write-back result, typically the ALU result.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits; matches the ALU operand width.
- ADDR_W, 5, register address width; depth is 2**ADDR_W = 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rna  input  ADDR_W  read address, port A (rs).
- rnb  input  ADDR_W  read address, port B (rt).
- qa  output  DATA_W  read data, port A; feeds ALU operand a.
- qb  output  DATA_W  read data, port B; feeds ALU operand b.
- we  input  1  write enable.
- wn  input  ADDR_W  write address (rd/rt).
- d  input  DATA_W  write data from the write-back stage.

Behaviour:
- Reset:
  - One clock is single; rst is synchronous and active-high.
  - On a rising clk edge with rst=1, all 32 registers are cleared to 0.
  - rst overrides we; a write presented in the reset cycle is discarded.
  - Asserting rst mid-program clears every register on that edge; no partial state survives.
- Reset values of outputs:
  - qa and qb are combinational.
  - After reset they read 0 for every address; register 0 reads 0 at all times.
- Write:
  - On the rising edge with rst=0, we=1 and wn!=0: reg[wn] <= d.
  - we=1 with wn=0 is silently ignored; reg0 stays 0.
  - we=0 leaves all registers unchanged.
- Read:
  - Purely combinational, zero-cycle latency: qa = reg[rna], qb = reg[rnb].
  - rna=0 or rnb=0 returns 0 regardless of any write.
  - Both ports read the same address simultaneously with identical results.
  - Reads of an address while a write to a different address is pending return the current stored value.
- Same-cycle write/read to the same address: governed by the optional feature below.
- Widths: no arithmetic; d is stored bit-exact with no sign or zero extension.
- Timing: a value written on edge N is visible on qa/qb from edge N onward, i.e. the cycle after we was sampled.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined (write-first forwarding):
  - If we=1, wn!=0 and rna==wn, then qa=d combinationally in the same cycle; likewise qb for rnb.
  - Bypass is inactive while rst=1; qa/qb read 0 on that cycle.
  - Removes one decode/write-back hazard stall.
- Undefined: read-first; qa/qb return the old stored value until the edge completes the write.

Test Plan:
- Reset: write 32'hDEADBEEF to r5, then assert rst for 1 cycle; set rna=5, rnb=31 -> qa=0, qb=0. A write of 32'h1 to r7 presented with rst=1 -> r7 still 0 afterward.
- Basic write/read: we=1, wn=3, d=127; next cycle wn=4, d=128; then rna=3, rnb=4 -> qa=127, qb=128.
- r0 protection: we=1, wn=0, d=32'hFFFFFFFF, clock edge; rna=0, rnb=0 -> qa=qb=0.
- Dual-port same address: write r9=32'h0000_0080; rna=rnb=9 -> qa=qb=32'h80. we=0 with d=32'h5 for 3 cycles -> r9 unchanged.
- Same-cycle hazard, r12 holds 32'h1: in one cycle we=1, wn=12, d=32'h2, rna=12 -> qa=32'h2 with REGFILE_BYPASS_EN, qa=32'h1 without it. In both builds qa=32'h2 after the edge.
- Full sweep: write reg[i]=i*32'h01010101 for i=1..31, then read all pairs (i, 31-i) -> every value matches; port reading address 0 -> 0.

Source files
------------

// File: rtl/regfile.sv
// regfile: 32 x 32-bit general-purpose register file for the decode stage.
//   - Two combinational read ports (qa/qb) feeding ALU operands a/b.
//   - One write port, written on the rising clk edge when we=1 and wn!=0.
//   - Register 0 is hardwired to zero.
//   - Synchronous, active-high rst clears every register and overrides we.
// Optional build macro: REGFILE_BYPASS_EN
//   defined   -> write-first: a write to the address being read shows up on
//                qa/qb in the same cycle; outputs read 0 while rst=1.
//   undefined -> read-first: qa/qb show the stored value until the edge.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rna,
    input  logic [ADDR_W-1:0] rnb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    input  logic              we,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] d
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Current contents of every register, register 0 included (constant zero).
    logic [DATA_W-1:0] w_regs [DEPTH];

    // Stored (pre-write) values selected by each read address.
    logic [DATA_W-1:0] w_qa_stored;
    logic [DATA_W-1:0] w_qb_stored;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // Register 0 has no storage; it reads as zero whatever is written.
                assign w_regs[gi] = '0;
            end else begin : g_store
                logic              w_wr_sel;
                logic [DATA_W-1:0] r_q;

                assign w_wr_sel = we && (wn == ADDR_W'(gi));

                // Clear on reset (reset wins over a concurrent write), else load d when selected.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_q <= '0;
                    end else if (w_wr_sel) begin
                        r_q <= d;
                    end
                end

                assign w_regs[gi] = r_q;
            end
        end
    endgenerate

    assign w_qa_stored = w_regs[rna];
    assign w_qb_stored = w_regs[rnb];

`ifdef REGFILE_BYPASS_EN
    // A write is forwarded only to a port reading the same non-zero address.
    logic w_byp_a;
    logic w_byp_b;

    assign w_byp_a = we && (wn != '0) && (rna == wn);
    assign w_byp_b = we && (wn != '0) && (rnb == wn);

    // Write-first read: reset forces zero, then forwarded data, then stored data.
    always_comb begin
        qa = w_qa_stored;
        qb = w_qb_stored;
        if (rst) begin
            qa = '0;
            qb = '0;
        end else begin
            if (w_byp_a) begin
                qa = d;
            end
            if (w_byp_b) begin
                qb = d;
            end
        end
    end
`else
    // Read-first: ports always show the value currently held in the array.
    assign qa = w_qa_stored;
    assign qb = w_qb_stored;
`endif

endmodule

// File: tb/tb_regfile.sv
// Testbench for regfile: a vector table for the directed scenarios, a few
// hand-written multi-cycle sequences, a full write/read sweep and a random
// phase checked against an array-based reference model.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rna, rnb, wn;
    logic [31:0] qa, qb, d;
    logic        we;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural register contents.
    logic [31:0] mdl [32];

    typedef struct {
        bit          r;
        bit          w;
        logic [4:0]  n;
        logic [31:0] dd;
        logic [4:0]  a;
        logic [4:0]  b;
        bit          chk;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t tbl [$];

    regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .rna (rna),
        .rnb (rnb),
        .qa  (qa),
        .qb  (qb),
        .we  (we),
        .wn  (wn),
        .d   (d)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Value a read port should show during the current cycle, from the rules.
    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (BYP && rst) return 32'h0;
        if (BYP && we && wn != 5'd0 && addr == wn) return d;
        return mdl[addr];
    endfunction

    // One clock cycle: drive, sample mid-cycle, optionally compare to the model,
    // then take the edge and advance the model.
    task automatic cycle(input bit r, input bit w, input logic [4:0] n,
                         input logic [31:0] dd, input logic [4:0] a,
                         input logic [4:0] b, input bit mchk,
                         output logic [31:0] oa, output logic [31:0] ob);
        rst = r; we = w; wn = n; d = dd; rna = a; rnb = b;
        #2;
        oa = qa;
        ob = qb;
        if (mchk) begin
            check($sformatf("model qa r=%0b we=%0b wn=%0d rna=%0d", r, w, n, a), qa, model_read(a));
            check($sformatf("model qb r=%0b we=%0b wn=%0d rnb=%0d", r, w, n, b), qb, model_read(b));
        end
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 32; k++) mdl[k] = 32'h0;
        end else if (w && n != 5'd0) begin
            mdl[n] = dd;
        end
        #1;
    endtask

    initial begin
        logic [31:0] oa, ob;
        logic [31:0] exp_v;

        rst = 1'b1; we = 1'b0; wn = '0; d = '0; rna = '0; rnb = '0;
        for (int k = 0; k < 32; k++) mdl[k] = 32'h0;
        @(posedge clk);
        #1;

        // ---------------- directed vector table ----------------
        //            r  w  wn  d             rna rnb chk exp_qa                 exp_qb
        tbl.push_back('{1, 0, 0,  32'h0,        0,  0,  0, 32'h0,                 32'h0});
        tbl.push_back('{0, 0, 0,  32'h0,        5,  31, 1, 32'h0,                 32'h0});
        tbl.push_back('{0, 1, 5,  32'hDEADBEEF, 0,  31, 1, 32'h0,                 32'h0});
        tbl.push_back('{0, 0, 0,  32'h0,        5,  31, 1, 32'hDEADBEEF,          32'h0});
        tbl.push_back('{1, 1, 7,  32'h1,        1,  2,  0, 32'h0,                 32'h0});
        tbl.push_back('{0, 0, 0,  32'h0,        5,  7,  1, 32'h0,                 32'h0});
        tbl.push_back('{0, 0, 0,  32'h0,        5,  31, 1, 32'h0,                 32'h0});
        tbl.push_back('{0, 1, 3,  32'd127,      4,  0,  1, 32'h0,                 32'h0});
        tbl.push_back('{0, 1, 4,  32'd128,      3,  0,  1, 32'd127,               32'h0});
        tbl.push_back('{0, 0, 0,  32'h0,        3,  4,  1, 32'd127,               32'd128});
        tbl.push_back('{0, 1, 0,  32'hFFFFFFFF, 3,  0,  1, 32'd127,               32'h0});
        tbl.push_back('{0, 0, 0,  32'h0,        0,  0,  1, 32'h0,                 32'h0});
        tbl.push_back('{0, 1, 9,  32'h80,       3,  4,  1, 32'd127,               32'd128});
        tbl.push_back('{0, 0, 9,  32'h5,        9,  9,  1, 32'h80,                32'h80});
        tbl.push_back('{0, 0, 9,  32'h5,        9,  9,  1, 32'h80,                32'h80});
        tbl.push_back('{0, 0, 9,  32'h5,        9,  9,  1, 32'h80,                32'h80});
        tbl.push_back('{0, 1, 12, 32'h1,        9,  9,  1, 32'h80,                32'h80});
        tbl.push_back('{0, 1, 12, 32'h2,        12, 0,  1, (BYP ? 32'h2 : 32'h1), 32'h0});
        tbl.push_back('{0, 0, 0,  32'h0,        12, 9,  1, 32'h2,                 32'h80});
        tbl.push_back('{1, 0, 0,  32'h0,        0,  0,  0, 32'h0,                 32'h0});
        tbl.push_back('{0, 0, 0,  32'h0,        12, 3,  1, 32'h0,                 32'h0});
        tbl.push_back('{0, 0, 0,  32'h0,        9,  4,  1, 32'h0,                 32'h0});

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].w, tbl[i].n, tbl[i].dd, tbl[i].a, tbl[i].b, 1'b0, oa, ob);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d qa", i), oa, tbl[i].ea);
                check($sformatf("vec%0d qb", i), ob, tbl[i].eb);
            end
        end

        // ------------- reset during a pending write to a read address -------------
        cycle(0, 1, 20, 32'h0000_00AA, 0, 0, 1'b0, oa, ob);
        cycle(1, 1, 20, 32'h0000_00BB, 20, 20, 1'b0, oa, ob);
        check("rst-cycle qa", oa, BYP ? 32'h0 : 32'h0000_00AA);
        cycle(0, 0, 0, 32'h0, 20, 0, 1'b0, oa, ob);
        check("after rst r20", oa, 32'h0);

        // ------------- hazard on port B, then visibility after the edge -------------
        cycle(0, 1, 17, 32'h1234_5678, 0, 0, 1'b0, oa, ob);
        cycle(0, 1, 17, 32'hCAFE_F00D, 0, 17, 1'b0, oa, ob);
        check("hazard qb", ob, BYP ? 32'hCAFE_F00D : 32'h1234_5678);
        cycle(0, 0, 0, 32'h0, 17, 17, 1'b0, oa, ob);
        check("post-edge qa r17", oa, 32'hCAFE_F00D);

        // ---------------- full sweep ----------------
        for (int i = 1; i < 32; i++) begin
            cycle(0, 1, 5'(i), 32'(i) * 32'h0101_0101, 0, 0, 1'b0, oa, ob);
        end
        for (int i = 0; i < 32; i++) begin
            cycle(0, 0, 0, 32'h0, 5'(i), 5'(31 - i), 1'b0, oa, ob);
            exp_v = 32'(i) * 32'h0101_0101;
            check($sformatf("sweep qa r%0d", i), oa, exp_v);
            exp_v = 32'(31 - i) * 32'h0101_0101;
            check($sformatf("sweep qb r%0d", 31 - i), ob, exp_v);
        end

        // ---------------- randomized against the model ----------------
        for (int t = 0; t < 400; t++) begin
            bit          rr, ww;
            logic [4:0]  nn, aa, bb;
            logic [31:0] vv;
            rr = ($urandom_range(0, 49) == 0);
            ww = ($urandom_range(0, 2) != 0);
            nn = 5'($urandom_range(0, 31));
            vv = $urandom;
            aa = ($urandom_range(0, 3) == 0) ? nn : 5'($urandom_range(0, 31));
            bb = ($urandom_range(0, 3) == 0) ? nn : 5'($urandom_range(0, 31));
            cycle(rr, ww, nn, vv, aa, bb, !rr || BYP, oa, ob);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
